// File: rtl/axi_llc_write_unit_if.sv
// Bus bundle for the LLC write unit.
// Groups the descriptor input, the W beat input, the B beat output, the
// data-way write request and the line-unlock request/grant into one
// interface.
//   slave  : view used by axi_llc_write_unit
//   master : view used by the surrounding logic (dispatcher, way arbiter, AXI port)
interface axi_llc_write_unit_if #(
    parameter int unsigned IdWidth           = 4,
    parameter int unsigned AddrWidth         = 32,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned IndexLength       = 4,
    parameter int unsigned BlockOffsetLength = 3,
    parameter int unsigned WayIndWidth       = 2
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    // descriptor
    logic [WayIndWidth-1:0]       desc_way_ind;
    logic [IndexLength-1:0]       desc_index_partition;
    logic [AddrWidth-1:0]         desc_addr;
    logic [7:0]                   desc_len;
    logic [2:0]                   desc_size;
    logic [1:0]                   desc_burst;
    logic [IdWidth-1:0]           desc_id;
    logic [1:0]                   desc_resp;
    logic                         desc_last;
    logic                         desc_valid;
    logic                         desc_ready;
    // W beats
    logic [DataWidth-1:0]         w_data;
    logic [StrbWidth-1:0]         w_strb;
    logic                         w_last;
    logic                         w_valid;
    logic                         w_ready;
    // B beats
    logic [IdWidth-1:0]           b_id;
    logic [1:0]                   b_resp;
    logic                         b_valid;
    logic                         b_ready;
    // data-way write request
    logic [1:0]                   way_cache_unit;
    logic                         way_we;
    logic [WayIndWidth-1:0]       way_ind;
    logic [IndexLength-1:0]       way_line_addr;
    logic [BlockOffsetLength-1:0] way_blk_offset;
    logic [DataWidth-1:0]         way_data;
    logic [StrbWidth-1:0]         way_be;
    logic                         way_valid;
    logic                         way_ready;
    // line unlock
    logic [IndexLength-1:0]       unlock_index;
    logic [WayIndWidth-1:0]       unlock_way_ind;
    logic                         unlock_req;
    logic                         unlock_gnt;

    modport slave (
        input  desc_way_ind, desc_index_partition, desc_addr, desc_len, desc_size,
               desc_burst, desc_id, desc_resp, desc_last, desc_valid,
        output desc_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        output way_cache_unit, way_we, way_ind, way_line_addr, way_blk_offset,
               way_data, way_be, way_valid,
        input  way_ready,
        output unlock_index, unlock_way_ind, unlock_req,
        input  unlock_gnt
    );

    modport master (
        output desc_way_ind, desc_index_partition, desc_addr, desc_len, desc_size,
               desc_burst, desc_id, desc_resp, desc_last, desc_valid,
        input  desc_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        input  way_cache_unit, way_we, way_ind, way_line_addr, way_blk_offset,
               way_data, way_be, way_valid,
        output way_ready,
        input  unlock_index, unlock_way_ind, unlock_req,
        output unlock_gnt
    );
endinterface

// File: rtl/axi_llc_write_unit.sv
// LLC write unit: takes a write descriptor, turns every W beat into one
// masked data-SRAM write to the descriptor's way/line, then releases the
// line lock and (on the last descriptor of an AXI burst) queues a B beat.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous reset, active low
//   test_i : FIFO test mode (no clock gating here, so it has no effect)
//   bus    : descriptor / W / B / way request / unlock bundle (slave view)
//
//   state  | meaning
//   IDLE   | waiting for a descriptor
//   BUSY   | moving W beats to the data way (or draining them on error)
//   FINISH | unlocking the line and pushing B, both in the same cycle
module axi_llc_write_unit #(
    parameter int unsigned ByteOffsetLength  = 3,
    parameter int unsigned BlockOffsetLength = 3,
    parameter int unsigned IndexLength       = 4,
    parameter int unsigned IdWidth           = 4,
    parameter int unsigned AddrWidth         = 32,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned WayIndWidth       = 2,
    parameter bit          CachePartition    = 1'b1,
    parameter int unsigned BFifoDepth        = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 test_i,
    axi_llc_write_unit_if.slave bus
);
    localparam logic [1:0] WChanUnit  = 2'd2;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam int unsigned PtrWidth  = (BFifoDepth > 1) ? $clog2(BFifoDepth) : 1;
    localparam int unsigned CntWidth  = $clog2(BFifoDepth + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;
    state_t state_q, state_d;

    logic [WayIndWidth-1:0] way_ind_q;
    logic [IndexLength-1:0] part_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [7:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [IdWidth-1:0]     id_q;
    logic [1:0]             resp_q;
    logic                   last_q;

    logic desc_load, beat_xfer, b_push, b_pop, b_full, resp_ok;
    logic [AddrWidth-1:0]   num_bytes, next_addr;
    logic [IndexLength-1:0] line_addr;

    logic [IdWidth-1:0]  b_id_mem   [BFifoDepth];
    logic [1:0]          b_resp_mem [BFifoDepth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;

    // w_last is deliberately ignored: the descriptor length decides the beat count.
    logic unused_ok;
    assign unused_ok = ^{test_i, bus.w_last};

    assign resp_ok   = (resp_q == RespOkay);
    assign num_bytes = AddrWidth'(1) << size_q;
    assign next_addr = (addr_q + num_bytes) & ~(num_bytes - AddrWidth'(1));

    if (CachePartition) begin : g_line_part
        assign line_addr = part_q;
    end else begin : g_line_index
        assign line_addr = addr_q[ByteOffsetLength+BlockOffsetLength +: IndexLength];
    end

    assign bus.way_cache_unit = WChanUnit;
    assign bus.way_we         = 1'b1;
    assign bus.way_ind        = way_ind_q;
    assign bus.way_line_addr  = line_addr;
    assign bus.way_blk_offset = addr_q[ByteOffsetLength +: BlockOffsetLength];
    assign bus.way_data       = bus.w_data;
    assign bus.way_be         = bus.w_strb;
    assign bus.unlock_index   = line_addr;
    assign bus.unlock_way_ind = way_ind_q;

    always_comb begin
        state_d        = state_q;
        desc_load      = 1'b0;
        beat_xfer      = 1'b0;
        b_push         = 1'b0;
        bus.desc_ready = 1'b0;
        bus.w_ready    = 1'b0;
        bus.way_valid  = 1'b0;
        bus.unlock_req = 1'b0;
        case (state_q)
            IDLE: begin
                bus.desc_ready = 1'b1;
                if (bus.desc_valid) begin
                    desc_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (resp_ok) begin
                    // Beat and SRAM write must handshake together.
                    bus.way_valid = bus.w_valid;
                    bus.w_ready   = bus.way_ready;
                    beat_xfer     = bus.w_valid & bus.way_ready;
                end else begin
                    bus.w_ready = 1'b1;
                    beat_xfer   = bus.w_valid;
                end
                if (beat_xfer && (len_q == 8'd0)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bus.unlock_req = resp_ok;
                // A grant is only taken once the B push can also happen.
                if ((!resp_ok || bus.unlock_gnt) && (!last_q || !b_full)) begin
                    b_push  = last_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            way_ind_q <= '0;
            part_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            resp_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (desc_load) begin
                way_ind_q <= bus.desc_way_ind;
                part_q    <= bus.desc_index_partition;
                addr_q    <= bus.desc_addr;
                len_q     <= bus.desc_len;
                size_q    <= bus.desc_size;
                burst_q   <= bus.desc_burst;
                id_q      <= bus.desc_id;
                resp_q    <= bus.desc_resp;
                last_q    <= bus.desc_last;
            end else if (beat_xfer && (len_q != 8'd0)) begin
                len_q <= len_q - 8'd1;
                if (burst_q != BurstFixed) begin
                    addr_q <= next_addr;
                end
            end
        end
    end

    // B response FIFO, registered output (no fall-through).
    assign b_full      = (cnt_q == CntWidth'(BFifoDepth));
    assign bus.b_valid = (cnt_q != '0);
    assign bus.b_id    = b_id_mem[rd_ptr_q];
    assign bus.b_resp  = b_resp_mem[rd_ptr_q];
    assign b_pop       = bus.b_valid & bus.b_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BFifoDepth); i++) begin
                b_id_mem[i]   <= '0;
                b_resp_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (b_push) begin
                b_id_mem[wr_ptr_q]   <= id_q;
                b_resp_mem[wr_ptr_q] <= resp_q;
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(BFifoDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (b_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(BFifoDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({b_push, b_pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule
